// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage RAW hazard scoreboard.
// Stage indices name the tracked slots behind decode.
package hazard_scoreboard_pkg;

   localparam int REG_ID_W = 5;

   localparam int STG_EX  = 0;
   localparam int STG_MEM = 1;
   localparam int STG_WB  = 2;

   typedef logic [REG_ID_W-1:0] reg_id_t;

   // A source only matches when the instruction actually reads it.
   function automatic logic src_match(input logic used, input reg_id_t src, input reg_id_t dst);
      return used && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: in-flight destination id with valid qualifier,
// plus the compare against both decode source registers.
module sb_entry
   import hazard_scoreboard_pkg::*;
#(
   parameter bit CMP_EN = 1'b1
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    advance,
   input  logic    in_valid,
   input  reg_id_t in_reg,
   input  reg_id_t id_rs,
   input  logic    id_rs_used,
   input  reg_id_t id_rt,
   input  logic    id_rt_used,
   output logic    valid,
   output reg_id_t gated_reg,
   output logic    hit
);

   reg_id_t reg_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         reg_q <= '0;
      end else if (advance) begin
         valid <= in_valid;
         reg_q <= in_reg;
      end
   end

   // Downstream consumers must never see a stale id from a dead slot.
   assign gated_reg = reg_q & {REG_ID_W{valid}};

   assign hit = CMP_EN & valid &
                (src_match(id_rs_used, id_rs, reg_q) | src_match(id_rt_used, id_rt, reg_q));

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard controller: tracks destinations from EX to WB,
// stalls decode on a match, and counts hazard-stall cycles.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned DEPTH     = 3,
   parameter bit          WB_BYPASS = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid,
   input  logic [REG_ID_W-1:0]       id_rs,
   input  logic                      id_rs_used,
   input  logic [REG_ID_W-1:0]       id_rt,
   input  logic                      id_rt_used,
   input  logic                      id_wr_en,
   input  logic [REG_ID_W-1:0]       id_wr_reg,
   input  logic                      hold,
   input  logic                      flush,
   output logic                      stall,
   output logic [REG_ID_W*DEPTH-1:0] stage_wr_reg,
   output logic [DEPTH-1:0]          stage_wr_en,
   output logic [CNT_W-1:0]          stall_cnt
);

   logic [DEPTH-1:0] hit;
   logic [DEPTH-1:0] slot_in_valid;
   reg_id_t          slot_in_reg [DEPTH];
   reg_id_t          slot_gated  [DEPTH];
   logic             hazard;
   logic             advance;

   // Flush outranks the hazard: the decode instruction is being killed anyway.
   assign hazard  = id_valid & ~flush & (|hit);
   assign stall   = hold | hazard;
   assign advance = ~hold;

   genvar k;
   generate
      for (k = 0; k < DEPTH; k++) begin : g_slot
         if (k == STG_EX) begin : g_ins
            assign slot_in_valid[k] = id_valid & id_wr_en & ~hazard & ~flush;
            assign slot_in_reg[k]   = id_wr_reg;
         end else if (k == STG_MEM) begin : g_kill
            // The redirecting instruction's shadow in EX dies on flush.
            assign slot_in_valid[k] = stage_wr_en[k-1] & ~flush;
            assign slot_in_reg[k]   = slot_in_reg_prev(k);
         end else begin : g_shift
            assign slot_in_valid[k] = stage_wr_en[k-1];
            assign slot_in_reg[k]   = slot_in_reg_prev(k);
         end

         sb_entry #(
            .CMP_EN (!(WB_BYPASS && (k == DEPTH-1)))
         ) u_entry (
            .clk        (clk),
            .rst        (rst),
            .advance    (advance),
            .in_valid   (slot_in_valid[k]),
            .in_reg     (slot_in_reg[k]),
            .id_rs      (id_rs),
            .id_rs_used (id_rs_used),
            .id_rt      (id_rt),
            .id_rt_used (id_rt_used),
            .valid      (stage_wr_en[k]),
            .gated_reg  (slot_gated[k]),
            .hit        (hit[k])
         );

         assign stage_wr_reg[REG_ID_W*k +: REG_ID_W] = slot_gated[k];
      end
   endgenerate

   // The gated id is exactly what a shifted slot needs: a dead slot carries 0.
   function automatic reg_id_t slot_in_reg_prev(input int idx);
      return slot_gated[idx-1];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (advance && hazard && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: three scoreboard configurations share stimulus and
// are compared against a behavioural model of in-flight register writes.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs;
   logic       id_rs_used;
   logic [4:0] id_rt;
   logic       id_rt_used;
   logic       id_wr_en;
   logic [4:0] id_wr_reg;
   logic       hold;
   logic       flush;

   logic        stall0, stall1, stall2;
   logic [14:0] wreg0, wreg1, wreg2;
   logic [2:0]  wen0, wen1, wen2;
   logic [15:0] cnt0, cnt1;
   logic [3:0]  cnt2;

   always #5 clk = ~clk;

   hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1'b1), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
      .hold(hold), .flush(flush), .stall(stall0), .stage_wr_reg(wreg0),
      .stage_wr_en(wen0), .stall_cnt(cnt0));

   hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1'b0), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
      .hold(hold), .flush(flush), .stall(stall1), .stage_wr_reg(wreg1),
      .stage_wr_en(wen1), .stall_cnt(cnt1));

   hazard_scoreboard #(.DEPTH(3), .WB_BYPASS(1'b1), .CNT_W(4)) dut2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .id_rt(id_rt), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
      .hold(hold), .flush(flush), .stall(stall2), .stage_wr_reg(wreg2),
      .stage_wr_en(wen2), .stall_cnt(cnt2));

   int n_checks = 0;
   int n_fail   = 0;

   // Model: per configuration, age-ordered list of pending writes (0 = youngest).
   bit         mv   [3][3];
   logic [4:0] mr   [3][3];
   int         mcnt [3];
   int         cmax [3] = '{65535, 65535, 15};
   bit         byp  [3] = '{1'b1, 1'b0, 1'b1};

   logic       cap_stall [3];
   logic [2:0] cap_wen0;
   logic [15:0] cap_cnt0;

   typedef struct {
      logic v; logic [4:0] rs; logic rsu; logic [4:0] rt; logic rtu;
      logic we; logic [4:0] wr; logic hold; logic flush;
      logic e_stall; logic [2:0] e_wen; int e_cnt;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cfg%0d got=%0h expected=%0h at %0t", name, c, got, exp, $time);
      end
   endtask

   // A write still pending in an age that decode cannot read around blocks it.
   function automatic bit m_hazard(input int c);
      if (!id_valid || flush) return 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (byp[c] && k == 2) continue;
         if (mv[c][k] && ((id_rs_used && id_rs == mr[c][k]) || (id_rt_used && id_rt == mr[c][k])))
            return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         mcnt[c] = 0;
         for (int k = 0; k < 3; k++) begin
            mv[c][k] = 1'b0;
            mr[c][k] = 5'd0;
         end
      end
   endtask

   task automatic model_step();
      bit hz;
      if (hold) return;
      for (int c = 0; c < 3; c++) begin
         hz = m_hazard(c);
         mv[c][2] = mv[c][1];          mr[c][2] = mr[c][1];
         mv[c][1] = mv[c][0] && !flush; mr[c][1] = mr[c][0];
         mv[c][0] = id_valid && id_wr_en && !hz && !flush;
         mr[c][0] = id_wr_reg;
         if (hz && mcnt[c] < cmax[c]) mcnt[c]++;
      end
   endtask

   task automatic check_cfg(input int c, input logic st, input logic [2:0] we,
                            input logic [14:0] wr, input logic [31:0] ct);
      logic [2:0]  ewe;
      logic [14:0] ewr;
      for (int k = 0; k < 3; k++) begin
         ewe[k] = mv[c][k];
         ewr[5*k +: 5] = mv[c][k] ? mr[c][k] : 5'd0;
      end
      chk("stall", c, {31'b0, st}, {31'b0, hold | m_hazard(c)});
      chk("stage_wr_en", c, {29'b0, we}, {29'b0, ewe});
      chk("stage_wr_reg", c, {17'b0, wr}, {17'b0, ewr});
      chk("stall_cnt", c, ct, mcnt[c]);
   endtask

   task automatic check_all();
      check_cfg(0, stall0, wen0, wreg0, {16'b0, cnt0});
      check_cfg(1, stall1, wen1, wreg1, {16'b0, cnt1});
      check_cfg(2, stall2, wen2, wreg2, {28'b0, cnt2});
   endtask

   task automatic do_cycle();
      @(negedge clk);
      check_all();
      cap_stall[0] = stall0; cap_stall[1] = stall1; cap_stall[2] = stall2;
      cap_wen0 = wen0; cap_cnt0 = cnt0;
      @(posedge clk);
      if (!rst) model_step();
      #1;
   endtask

   task automatic set_in(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                         input logic rtu, input logic we, input logic [4:0] wr,
                         input logic h, input logic f);
      id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
      id_wr_en = we; id_wr_reg = wr; hold = h; flush = f;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      model_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [3:0] e_byp, e_nobyp, g_byp, g_nobyp;

      //          v  rs rsu rt rtu we wr  h  f | stall wen     cnt
      tbl[0]  = '{1, 0, 0, 0, 0, 1, 5,  0, 0,  0, 3'b000, 0};
      tbl[1]  = '{1, 5, 1, 0, 0, 1, 6,  0, 0,  1, 3'b001, 0};
      tbl[2]  = '{1, 5, 1, 0, 0, 1, 6,  0, 0,  1, 3'b010, 1};
      tbl[3]  = '{1, 5, 1, 0, 0, 1, 6,  0, 0,  0, 3'b100, 2};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 3'b001, 2};
      tbl[5]  = '{1, 0, 0, 6, 0, 0, 9,  0, 0,  0, 3'b010, 2};
      tbl[6]  = '{1, 0, 0, 0, 0, 1, 3,  0, 0,  0, 3'b100, 2};
      tbl[7]  = '{1, 3, 1, 0, 0, 1, 8,  0, 1,  0, 3'b001, 2};
      tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 3'b000, 2};
      tbl[9]  = '{1, 0, 0, 0, 0, 1, 9,  0, 0,  0, 3'b000, 2};
      tbl[10] = '{1, 9, 1, 0, 0, 1, 10, 1, 0,  1, 3'b001, 2};
      tbl[11] = '{1, 9, 1, 0, 0, 1, 10, 1, 1,  1, 3'b001, 2};
      tbl[12] = '{1, 9, 1, 0, 0, 1, 10, 1, 0,  1, 3'b001, 2};
      tbl[13] = '{1, 9, 1, 0, 0, 1, 10, 1, 0,  1, 3'b001, 2};
      tbl[14] = '{1, 9, 1, 0, 0, 1, 10, 0, 0,  1, 3'b001, 2};
      tbl[15] = '{1, 9, 1, 0, 0, 1, 10, 0, 0,  1, 3'b010, 3};
      tbl[16] = '{1, 9, 1, 0, 0, 1, 10, 0, 0,  0, 3'b100, 4};
      tbl[17] = '{1, 0, 0, 0, 0, 1, 0,  0, 0,  0, 3'b001, 4};
      tbl[18] = '{1, 0, 0, 0, 1, 0, 0,  0, 0,  1, 3'b011, 4};
      tbl[19] = '{0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 3'b110, 5};

      apply_reset();

      for (int i = 0; i < 20; i++) begin
         set_in(tbl[i].v, tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu,
                tbl[i].we, tbl[i].wr, tbl[i].hold, tbl[i].flush);
         do_cycle();
         chk($sformatf("tbl%0d_stall", i), 0, {31'b0, cap_stall[0]}, {31'b0, tbl[i].e_stall});
         chk($sformatf("tbl%0d_wen", i), 0, {29'b0, cap_wen0}, {29'b0, tbl[i].e_wen});
         chk($sformatf("tbl%0d_cnt", i), 0, {16'b0, cap_cnt0}, tbl[i].e_cnt);
      end

      // Producer of r7 reaching WB: bypassed config reads through, the other waits.
      apply_reset();
      set_in(1, 0, 0, 0, 0, 1, 7, 0, 0);
      do_cycle();
      set_in(1, 7, 1, 0, 0, 0, 0, 0, 0);
      e_byp = 4'b0011; e_nobyp = 4'b0111;
      for (int i = 0; i < 4; i++) begin
         do_cycle();
         g_byp[i] = cap_stall[0];
         g_nobyp[i] = cap_stall[1];
      end
      chk("wb_bypass_seq", 0, {28'b0, g_byp}, {28'b0, e_byp});
      chk("wb_nobypass_seq", 1, {28'b0, g_nobyp}, {28'b0, e_nobyp});

      // Chain of self-dependent instructions: 20 hazard edges in 31 cycles.
      apply_reset();
      set_in(1, 5, 1, 0, 0, 1, 5, 0, 0);
      for (int i = 0; i < 31; i++) do_cycle();
      chk("sat_cnt_w4", 2, {28'b0, cnt2}, 32'd15);
      chk("chain_cnt_w16", 0, {16'b0, cnt0}, 32'd20);
      chk("pre_rst_stall", 0, {31'b0, stall0}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_stall", 0, {31'b0, stall0}, 32'd0);
      chk("async_rst_cnt", 0, {16'b0, cnt0}, 32'd0);
      chk("async_rst_cnt_w4", 2, {28'b0, cnt2}, 32'd0);
      chk("async_rst_wen", 0, {29'b0, wen0}, 32'd0);
      chk("async_rst_wreg", 0, {17'b0, wreg0}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 800; i++) begin
         set_in(($urandom % 8) != 0, 5'($urandom % 6), 1'($urandom), 5'($urandom % 6),
                1'($urandom), ($urandom % 4) != 0, 5'($urandom % 6),
                ($urandom % 8) == 0, ($urandom % 10) == 0);
         do_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
